axi_apb_req_frontend: RTL and testbench

AXI4-Lite slave front end that feeds the APB subsystem's request interface (`transfer`/`read`/`write`, addresses, write data) and returns its completion, read data and error as AXI responses. It buffers one AW, one W and one AR beat, arbitrates read against write, and drives exactly one APB request at a time. It adds a timeout so a hung APB completion still produces an AXI response.

---
 rtl/apb_bridge_pkg.sv | 35 +++
 rtl/axi_hold_reg.sv | 45 ++++
 rtl/axi_apb_req_frontend.sv | 186 ++++++++++++++++++
 tb/tb_axi_apb_req_frontend.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_bridge_pkg.sv
// ============================================================================
//  Module      : apb_bridge_pkg
//  Description : Shared response codes, FSM state and grant encodings for the
//                AXI4-Lite to APB request front end.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package apb_bridge_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_XFER = 3'd1,
        ST_WR_RESP = 3'd2,
        ST_RD_XFER = 3'd3,
        ST_RD_RESP = 3'd4
    } state_t;

    // Direction of the most recent grant, used for read/write alternation.
    typedef enum logic {
        GRANT_WRITE = 1'b0,
        GRANT_READ  = 1'b1
    } grant_t;

    // AXI response code for an APB completion error flag.
    function automatic logic [1:0] resp_of(input logic err);
        return err ? RESP_SLVERR : RESP_OKAY;
    endfunction

endpackage

`default_nettype wire

// File: rtl/axi_hold_reg.sv
// ============================================================================
//  Module      : axi_hold_reg
//  Description : One-deep AXI channel holding register. Ready while empty,
//                loads on handshake, emptied by an explicit clear.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_hold_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_clear,
    output logic             o_full,
    output logic [WIDTH-1:0] o_data
);

    logic             r_full;
    logic [WIDTH-1:0] r_data;

    // Load on handshake; clear has priority and cannot coincide with a load
    // because ready is low whenever the hold is full.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_full <= 1'b0;
            r_data <= '0;
        end else if (i_clear) begin
            r_full <= 1'b0;
        end else if (i_valid && !r_full) begin
            r_full <= 1'b1;
            r_data <= i_data;
        end
    end

    assign o_ready = !r_full;
    assign o_full  = r_full;
    assign o_data  = r_data;

endmodule

`default_nettype wire

// File: rtl/axi_apb_req_frontend.sv
// ============================================================================
//  Module      : axi_apb_req_frontend
//  Description : AXI4-Lite slave front end driving one APB request at a time,
//                with read/write alternation and a completion timeout that
//                forces SLVERR when the APB side never answers.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_apb_req_frontend
    import apb_bridge_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16   // must be >= 2
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    // write address
    input  logic [ADDR_WIDTH-1:0] AWADDR,
    input  logic                  AWVALID,
    output logic                  AWREADY,
    // write data
    input  logic [DATA_WIDTH-1:0] WDATA,
    input  logic                  WVALID,
    output logic                  WREADY,
    // write response
    output logic [1:0]            BRESP,
    output logic                  BVALID,
    input  logic                  BREADY,
    // read address
    input  logic [ADDR_WIDTH-1:0] ARADDR,
    input  logic                  ARVALID,
    output logic                  ARREADY,
    // read data
    output logic [DATA_WIDTH-1:0] RDATA,
    output logic [1:0]            RRESP,
    output logic                  RVALID,
    input  logic                  RREADY,
    // APB subsystem request interface
    output logic                  transfer,
    output logic                  read,
    output logic                  write,
    output logic [ADDR_WIDTH-1:0] apb_waddr,
    output logic [ADDR_WIDTH-1:0] apb_raddr,
    output logic [DATA_WIDTH-1:0] apb_wdata,
    input  logic [DATA_WIDTH-1:0] apb_rdata,
    input  logic                  error,
    input  logic                  apb_done
);

    localparam int              c_CNT_W        = $clog2(TIMEOUT_CYCLES);
    localparam logic [c_CNT_W-1:0] c_TIMEOUT_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);

    state_t                r_state;
    grant_t                r_last_grant;
    logic [c_CNT_W-1:0]    r_cnt;
    logic [1:0]            r_bresp;
    logic [1:0]            r_rresp;
    logic [DATA_WIDTH-1:0] r_rdata;

    logic w_aw_full;
    logic w_w_full;
    logic w_ar_full;
    logic w_clear_wr;
    logic w_clear_rd;
    logic w_wr_elig;
    logic w_rd_elig;
    logic w_timeout;

    // The write pair is released together once its response is accepted.
    assign w_clear_wr = (r_state == ST_WR_RESP) && BREADY;
    assign w_clear_rd = (r_state == ST_RD_RESP) && RREADY;

    axi_hold_reg #(.WIDTH(ADDR_WIDTH)) u_aw_hold (
        .clk     (PCLK),
        .rst     (PRESET),
        .i_valid (AWVALID),
        .o_ready (AWREADY),
        .i_data  (AWADDR),
        .i_clear (w_clear_wr),
        .o_full  (w_aw_full),
        .o_data  (apb_waddr)
    );

    axi_hold_reg #(.WIDTH(DATA_WIDTH)) u_w_hold (
        .clk     (PCLK),
        .rst     (PRESET),
        .i_valid (WVALID),
        .o_ready (WREADY),
        .i_data  (WDATA),
        .i_clear (w_clear_wr),
        .o_full  (w_w_full),
        .o_data  (apb_wdata)
    );

    axi_hold_reg #(.WIDTH(ADDR_WIDTH)) u_ar_hold (
        .clk     (PCLK),
        .rst     (PRESET),
        .i_valid (ARVALID),
        .o_ready (ARREADY),
        .i_data  (ARADDR),
        .i_clear (w_clear_rd),
        .o_full  (w_ar_full),
        .o_data  (apb_raddr)
    );

    assign w_wr_elig = w_aw_full && w_w_full;
    assign w_rd_elig = w_ar_full;
    assign w_timeout = (r_cnt == c_TIMEOUT_LAST);

    // Request FSM with arbitration, timeout counting and response capture.
    // A real completion in the last allowed cycle takes precedence over timeout.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_state      <= ST_IDLE;
            r_last_grant <= GRANT_READ;
            r_cnt        <= '0;
            r_bresp      <= RESP_OKAY;
            r_rresp      <= RESP_OKAY;
            r_rdata      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_cnt <= '0;
                    if (w_wr_elig && (!w_rd_elig || r_last_grant == GRANT_READ)) begin
                        r_state      <= ST_WR_XFER;
                        r_last_grant <= GRANT_WRITE;
                    end else if (w_rd_elig) begin
                        r_state      <= ST_RD_XFER;
                        r_last_grant <= GRANT_READ;
                    end
                end
                ST_WR_XFER: begin
                    if (apb_done) begin
                        r_bresp <= resp_of(error);
                        r_state <= ST_WR_RESP;
                    end else if (w_timeout) begin
                        r_bresp <= RESP_SLVERR;
                        r_state <= ST_WR_RESP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_WR_RESP: begin
                    if (BREADY) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_RD_XFER: begin
                    if (apb_done) begin
                        r_rdata <= apb_rdata;
                        r_rresp <= resp_of(error);
                        r_state <= ST_RD_RESP;
                    end else if (w_timeout) begin
                        r_rdata <= '0;
                        r_rresp <= RESP_SLVERR;
                        r_state <= ST_RD_RESP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_RD_RESP: begin
                    if (RREADY) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign transfer = (r_state == ST_WR_XFER) || (r_state == ST_RD_XFER);
    assign write    = (r_state == ST_WR_XFER);
    assign read     = (r_state == ST_RD_XFER);
    assign BVALID   = (r_state == ST_WR_RESP);
    assign RVALID   = (r_state == ST_RD_RESP);
    assign BRESP    = r_bresp;
    assign RRESP    = r_rresp;
    assign RDATA    = r_rdata;

endmodule

`default_nettype wire

// File: tb/tb_axi_apb_req_frontend.sv
// ============================================================================
//  Module      : tb_axi_apb_req_frontend
//  Description : Scoreboard bench for axi_apb_req_frontend: directed AXI
//                stimulus, a simple APB completion responder, and monitors
//                that compare APB requests and AXI responses against queues.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_axi_apb_req_frontend;

    localparam int         AW = 32;
    localparam int         DW = 32;
    localparam int         TO = 16;
    localparam logic [1:0] c_OKAY   = 2'b00;
    localparam logic [1:0] c_SLVERR = 2'b10;

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } req_t;

    typedef struct {
        logic [1:0]    resp;
        logic [DW-1:0] data;
    } rsp_t;

    logic          PCLK = 1'b0;
    logic          PRESET;
    logic [AW-1:0] AWADDR;
    logic          AWVALID;
    logic          AWREADY;
    logic [DW-1:0] WDATA;
    logic          WVALID;
    logic          WREADY;
    logic [1:0]    BRESP;
    logic          BVALID;
    logic          BREADY;
    logic [AW-1:0] ARADDR;
    logic          ARVALID;
    logic          ARREADY;
    logic [DW-1:0] RDATA;
    logic [1:0]    RRESP;
    logic          RVALID;
    logic          RREADY;
    logic          transfer;
    logic          read;
    logic          write;
    logic [AW-1:0] apb_waddr;
    logic [AW-1:0] apb_raddr;
    logic [DW-1:0] apb_wdata;
    logic [DW-1:0] apb_rdata;
    logic          error;
    logic          apb_done;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    req_t       exp_req[$];
    logic [1:0] exp_b[$];
    rsp_t       exp_r[$];

    // responder controls
    int            apb_delay    = 2;
    bit            apb_hang     = 1'b0;
    bit            apb_err      = 1'b0;
    logic [DW-1:0] apb_rd_value = '0;
    int            force_cnt    = 0;
    int            resp_xc      = 0;
    int            resp_seen    = 0;

    // monitor state
    logic       mon_prev_xfer = 1'b0;
    req_t       mon_req;
    logic [1:0] mon_b;
    rsp_t       mon_r;

    int t0;
    int t1;

    axi_apb_req_frontend #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .PCLK      (PCLK),
        .PRESET    (PRESET),
        .AWADDR    (AWADDR),
        .AWVALID   (AWVALID),
        .AWREADY   (AWREADY),
        .WDATA     (WDATA),
        .WVALID    (WVALID),
        .WREADY    (WREADY),
        .BRESP     (BRESP),
        .BVALID    (BVALID),
        .BREADY    (BREADY),
        .ARADDR    (ARADDR),
        .ARVALID   (ARVALID),
        .ARREADY   (ARREADY),
        .RDATA     (RDATA),
        .RRESP     (RRESP),
        .RVALID    (RVALID),
        .RREADY    (RREADY),
        .transfer  (transfer),
        .read      (read),
        .write     (write),
        .apb_waddr (apb_waddr),
        .apb_raddr (apb_raddr),
        .apb_wdata (apb_wdata),
        .apb_rdata (apb_rdata),
        .error     (error),
        .apb_done  (apb_done)
    );

    always #5 PCLK = ~PCLK;

    // Free-running cycle counter for latency measurements.
    always @(posedge PCLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic push_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_t t;
        t.wr = 1'b1; t.addr = a; t.data = d;
        exp_req.push_back(t);
    endtask

    task automatic push_rd(input logic [AW-1:0] a);
        req_t t;
        t.wr = 1'b0; t.addr = a; t.data = '0;
        exp_req.push_back(t);
    endtask

    task automatic push_r(input logic [1:0] r, input logic [DW-1:0] d);
        rsp_t t;
        t.resp = r; t.data = d;
        exp_r.push_back(t);
    endtask

    // APB side: pulse apb_done apb_delay+1 cycles into a transfer unless hung;
    // a bump of force_cnt produces one stray pulse regardless of state.
    initial begin
        apb_done  = 1'b0;
        error     = 1'b0;
        apb_rdata = '0;
        forever begin
            @(posedge PCLK); #1;
            apb_done = 1'b0;
            if (force_cnt != resp_seen) begin
                resp_seen = force_cnt;
                apb_done  = 1'b1;
                error     = 1'b0;
                apb_rdata = 32'hFFFF_FFFF;
            end else if (transfer && !apb_hang) begin
                if (resp_xc == apb_delay) begin
                    apb_done  = 1'b1;
                    error     = apb_err;
                    apb_rdata = apb_rd_value;
                end
                resp_xc++;
            end
            if (!transfer) resp_xc = 0;
        end
    end

    // Monitor: compare each new APB request and each AXI response handshake.
    initial begin
        forever begin
            @(negedge PCLK);
            if (!PRESET && transfer && !mon_prev_xfer) begin
                if (exp_req.size() == 0) begin
                    n_checks++;
                    $display("FAIL req_unexpected: transfer rose, write=%0b read=%0b, none expected", write, read);
                end else begin
                    mon_req = exp_req.pop_front();
                    check("req_write", {63'd0, write}, {63'd0, mon_req.wr});
                    check("req_read", {63'd0, read}, {63'd0, !mon_req.wr});
                    if (mon_req.wr) begin
                        check("req_waddr", {32'd0, apb_waddr}, {32'd0, mon_req.addr});
                        check("req_wdata", {32'd0, apb_wdata}, {32'd0, mon_req.data});
                    end else begin
                        check("req_raddr", {32'd0, apb_raddr}, {32'd0, mon_req.addr});
                    end
                end
            end
            mon_prev_xfer = transfer && !PRESET;
            if (BVALID && BREADY) begin
                if (exp_b.size() == 0) begin
                    n_checks++;
                    $display("FAIL b_unexpected: BVALID handshake with BRESP=%b, none expected", BRESP);
                end else begin
                    mon_b = exp_b.pop_front();
                    check("bresp", {62'd0, BRESP}, {62'd0, mon_b});
                end
            end
            if (RVALID && RREADY) begin
                if (exp_r.size() == 0) begin
                    n_checks++;
                    $display("FAIL r_unexpected: RVALID handshake with RRESP=%b RDATA=%h, none expected", RRESP, RDATA);
                end else begin
                    mon_r = exp_r.pop_front();
                    check("rresp", {62'd0, RRESP}, {62'd0, mon_r.resp});
                    check("rdata", {32'd0, RDATA}, {32'd0, mon_r.data});
                end
            end
        end
    end

    // Drive the selected AXI request channels; each drops after its handshake.
    task automatic issue(input bit do_aw, input logic [AW-1:0] aw,
                         input bit do_w,  input logic [DW-1:0] wd,
                         input bit do_ar, input logic [AW-1:0] ar);
        int n;
        bit aw_hs, w_hs, ar_hs;
        n = 0;
        AWADDR = aw; AWVALID = do_aw;
        WDATA  = wd; WVALID  = do_w;
        ARADDR = ar; ARVALID = do_ar;
        while ((AWVALID || WVALID || ARVALID) && n < 50) begin
            @(negedge PCLK);
            aw_hs = AWVALID && AWREADY;
            w_hs  = WVALID && WREADY;
            ar_hs = ARVALID && ARREADY;
            @(posedge PCLK); #1;
            if (aw_hs) AWVALID = 1'b0;
            if (w_hs)  WVALID  = 1'b0;
            if (ar_hs) ARVALID = 1'b0;
            n++;
        end
        if (AWVALID || WVALID || ARVALID) begin
            n_checks++;
            $display("FAIL issue_timeout: valids still high aw=%0b w=%0b ar=%0b", AWVALID, WVALID, ARVALID);
            AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
        end
    endtask

    function automatic logic sig(input int s);
        case (s)
            0:       return transfer;
            1:       return BVALID;
            default: return RVALID;
        endcase
    endfunction

    task automatic wait_for(input string name, input int s, input int budget);
        int n;
        n = 0;
        while (!sig(s) && n < budget) begin
            @(posedge PCLK); #1;
            n++;
        end
        if (!sig(s)) begin
            n_checks++;
            $display("FAIL %s: signal not seen within %0d cycles", name, budget);
        end
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while ((exp_req.size() + exp_b.size() + exp_r.size() > 0 || transfer || BVALID || RVALID)
               && n < budget) begin
            @(posedge PCLK); #1;
            n++;
        end
        if (exp_req.size() + exp_b.size() + exp_r.size() > 0 || transfer || BVALID || RVALID) begin
            n_checks++;
            $display("FAIL %s: not idle after %0d cycles, pending req=%0d b=%0d r=%0d",
                     name, budget, exp_req.size(), exp_b.size(), exp_r.size());
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        PRESET  = 1'b1;
        AWADDR  = '0; AWVALID = 1'b0;
        WDATA   = '0; WVALID  = 1'b0;
        ARADDR  = '0; ARVALID = 1'b0;
        BREADY  = 1'b1;
        RREADY  = 1'b1;
        repeat (3) @(posedge PCLK);
        #1;

        // reset state
        check("rst_ctrl", {59'd0, transfer, read, write, BVALID, RVALID}, 64'd0);
        check("rst_resp", {60'd0, BRESP, RRESP}, 64'd0);
        check("rst_rdata", {32'd0, RDATA}, 64'd0);
        check("rst_waddr_wdata", {apb_waddr, apb_wdata}, 64'd0);
        check("rst_raddr", {32'd0, apb_raddr}, 64'd0);
        check("rst_ready", {61'd0, AWREADY, WREADY, ARREADY}, 64'd7);
        PRESET = 1'b0;
        @(posedge PCLK); #1;

        // single write, B held off for a few cycles
        BREADY = 1'b0;
        push_wr(32'h0000_0004, 32'hDEAD_BEEF);
        exp_b.push_back(c_OKAY);
        issue(1'b1, 32'h0000_0004, 1'b1, 32'hDEAD_BEEF, 1'b0, '0);
        check("wr_latency_pre", {63'd0, transfer}, 64'd0);
        @(posedge PCLK); #1;
        check("wr_latency", {63'd0, transfer}, 64'd1);
        wait_for("wr_bvalid", 1, 40);
        repeat (3) @(posedge PCLK);
        #1;
        check("b_held", {61'd0, BVALID, BRESP}, {61'd0, 1'b1, c_OKAY});
        BREADY = 1'b1;
        @(posedge PCLK); #1;
        check("b_done", {61'd0, BVALID, AWREADY, WREADY}, 64'd3);

        // read completing with error
        apb_err      = 1'b1;
        apb_rd_value = 32'h1234_5678;
        push_rd(32'h0000_0010);
        push_r(c_SLVERR, 32'h1234_5678);
        issue(1'b0, '0, 1'b0, '0, 1'b1, 32'h0000_0010);
        drain("rd_err_drain", 60);
        apb_err = 1'b0;

        // W before AW
        push_wr(32'h0000_0008, 32'hCAFE_0001);
        exp_b.push_back(c_OKAY);
        issue(1'b0, '0, 1'b1, 32'hCAFE_0001, 1'b0, '0);
        for (int i = 0; i < 3; i++) begin
            check("wfirst_no_xfer", {63'd0, transfer}, 64'd0);
            check("wfirst_wready", {63'd0, WREADY}, 64'd0);
            @(posedge PCLK); #1;
        end
        issue(1'b1, 32'h0000_0008, 1'b0, '0, 1'b0, '0);
        check("wfirst_pre", {63'd0, transfer}, 64'd0);
        wait_for("wfirst_xfer", 0, 10);
        wait_for("wfirst_bvalid", 1, 40);
        check("wfirst_wready_resp", {63'd0, WREADY}, 64'd0);
        @(posedge PCLK); #1;
        check("wfirst_wready_free", {63'd0, WREADY}, 64'd1);

        // contention right after reset: write wins
        PRESET = 1'b1;
        @(posedge PCLK); #1;
        PRESET = 1'b0;
        apb_rd_value = 32'h0BAD_F00D;
        push_wr(32'h0000_0100, 32'hA5A5_0001);
        push_rd(32'h0000_0200);
        exp_b.push_back(c_OKAY);
        push_r(c_OKAY, 32'h0BAD_F00D);
        issue(1'b1, 32'h0000_0100, 1'b1, 32'hA5A5_0001, 1'b1, 32'h0000_0200);
        drain("cont1_drain", 100);

        // lone write leaves the last grant on write
        push_wr(32'h0000_0104, 32'h1111_1111);
        exp_b.push_back(c_OKAY);
        issue(1'b1, 32'h0000_0104, 1'b1, 32'h1111_1111, 1'b0, '0);
        drain("lone_wr_drain", 60);

        // contention again: read wins this time
        push_rd(32'h0000_0204);
        push_wr(32'h0000_0108, 32'h2222_2222);
        push_r(c_OKAY, 32'h0BAD_F00D);
        exp_b.push_back(c_OKAY);
        issue(1'b1, 32'h0000_0108, 1'b1, 32'h2222_2222, 1'b1, 32'h0000_0204);
        drain("cont2_drain", 100);

        // timeout on a read, then a stray apb_done during the response
        apb_hang = 1'b1;
        RREADY   = 1'b0;
        push_rd(32'h0000_0300);
        push_r(c_SLVERR, 32'h0000_0000);
        issue(1'b0, '0, 1'b0, '0, 1'b1, 32'h0000_0300);
        wait_for("to_xfer", 0, 10);
        t0 = cyc;
        wait_for("to_rvalid", 2, 40);
        t1 = cyc;
        check("to_latency", 64'(t1 - t0), 64'(TO));
        force_cnt++;
        repeat (3) @(posedge PCLK);
        #1;
        check("to_late_done", {29'd0, transfer, RVALID, RRESP, RDATA}, {29'd0, 1'b0, 1'b1, c_SLVERR, 32'd0});
        RREADY = 1'b1;
        drain("to_drain", 20);

        // reset in the middle of a write transfer
        push_wr(32'h0000_0400, 32'h5555_AAAA);
        issue(1'b1, 32'h0000_0400, 1'b1, 32'h5555_AAAA, 1'b0, '0);
        wait_for("rstmid_xfer", 0, 10);
        @(posedge PCLK); #1;
        check("rstmid_in_xfer", {62'd0, transfer, write}, 64'd3);
        PRESET = 1'b1;
        @(posedge PCLK); #1;
        check("rstmid_drop", {62'd0, transfer, BVALID}, 64'd0);
        PRESET = 1'b0;
        @(posedge PCLK); #1;
        check("rstmid_ready", {61'd0, AWREADY, WREADY, ARREADY}, 64'd7);
        repeat (4) @(posedge PCLK);
        #1;
        check("rstmid_no_b", {62'd0, BVALID, transfer}, 64'd0);
        apb_hang = 1'b0;

        check("sb_empty", 64'(exp_req.size() + exp_b.size() + exp_r.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
